// File: rtl/axi_llc_arcane_pkg.sv
// Shared types for the ARCANE LLC control-path blocks.
package axi_llc_arcane_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ISOLATE = 3'd1,
    ARB_LOCK    = 3'd2,
    ARB_RELEASE = 3'd3,
    ARB_ERR     = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    LOCK_ERR_NONE        = 2'd0,
    LOCK_ERR_ISO_TIMEOUT = 2'd1,
    LOCK_ERR_REL_TIMEOUT = 2'd2,
    LOCK_ERR_ISO_LOST    = 2'd3
  } lock_err_e;

endpackage

// File: rtl/axi_llc_arcane_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module axi_llc_arcane_rr_pick #(
  parameter int NumReq = 2,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic              valid,
  output logic [IdxW-1:0]   idx
);

  int cand;

  // Walk from the farthest candidate back to ptr so the nearest hit is assigned last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (cand < NumReq && req[cand]) begin
        valid = 1'b1;
        idx   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_llc_arcane_lock_arb.sv
// Round-robin lock arbiter that isolates the LLC before granting exclusive ownership,
// with bounded isolate/release phases and a sticky, clearable error record.
module axi_llc_arcane_lock_arb
  import axi_llc_arcane_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 1024,
  parameter int IdxW          = $clog2(NumReq),
  parameter int CntW          = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] lock_req_i,
  input  logic              llc_isolated_i,
  input  logic              ar_unit_busy_i,
  input  logic              aw_unit_busy_i,
  input  logic              err_clr_i,
  output logic [NumReq-1:0] lock_gnt_o,
  output logic [IdxW-1:0]   owner_o,
  output logic              llc_isolate_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  arb_state_e      state_q, state_d;
  lock_err_e       code_q, code_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic            timeout_hit;
  logic            units_idle;
  logic            owner_req;

  axi_llc_arcane_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req   (lock_req_i),
    .ptr   (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));
  assign units_idle  = !ar_unit_busy_i && !aw_unit_busy_i;
  assign owner_req   = lock_req_i[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    code_d  = code_q;
    err_d   = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = ARB_ISOLATE;
        end
      end
      ARB_ISOLATE: begin
        if (!owner_req) begin
          state_d = ARB_RELEASE;
        end else if (llc_isolated_i && units_idle) begin
          state_d = ARB_LOCK;
        end else if (timeout_hit) begin
          state_d = ARB_ERR;
          code_d  = LOCK_ERR_ISO_TIMEOUT;
          err_d   = 1'b1;
        end
      end
      ARB_LOCK: begin
        if (!owner_req) begin
          state_d = ARB_RELEASE;
        end else if (!llc_isolated_i) begin
          state_d = ARB_ERR;
          code_d  = LOCK_ERR_ISO_LOST;
          err_d   = 1'b1;
        end
      end
      ARB_RELEASE: begin
        if (!llc_isolated_i) begin
          state_d = ARB_IDLE;
          rr_d    = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
        end else if (timeout_hit) begin
          state_d = ARB_ERR;
          code_d  = LOCK_ERR_REL_TIMEOUT;
          err_d   = 1'b1;
        end
      end
      ARB_ERR: begin
        if (err_clr_i) begin
          state_d = ARB_RELEASE;
          code_d  = LOCK_ERR_NONE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Counter restarts on every transition and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ARB_ISOLATE || state_q == ARB_RELEASE) && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ARB_IDLE;
      owner_q       <= '0;
      rr_q          <= '0;
      cnt_q         <= '0;
      code_q        <= LOCK_ERR_NONE;
      err_q         <= 1'b0;
      lock_gnt_o    <= '0;
      llc_isolate_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      err_q         <= err_d;
      lock_gnt_o    <= (state_d == ARB_LOCK) ? (NumReq'(1) << owner_d) : '0;
      llc_isolate_o <= (state_d == ARB_ISOLATE) || (state_d == ARB_LOCK) ||
                       (state_d == ARB_ERR);
      busy_o        <= (state_d != ARB_IDLE);
    end
  end

  assign owner_o    = owner_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule
